// File: rtl/comms_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | comms_pkg: shared constants, state encoding and byte-select helper |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package comms_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         MAX_LEN     = 29;
    localparam int         FRAME_BYTES = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_EVAL   = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    function automatic logic [7:0] frame_byte(input logic [8*FRAME_BYTES-1:0] frame,
                                              input logic [4:0]               idx);
        return frame[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/comms_rx_csum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | comms_rx_csum: 8-bit modulo-256 clear/add accumulator              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module comms_rx_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= 8'd0;
        end else if (add) begin
            sum <= sum + data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_frame_unpacker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_frame_unpacker: validates a 32-byte frame and streams payload   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rx_frame_unpacker
    import comms_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = comms_pkg::SYNC_BYTE,
    parameter int         MAX_LEN   = comms_pkg::MAX_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         newData,
    input  logic [255:0] receiveBuffer,
    output logic [7:0]   byteOut,
    output logic         byteValid,
    input  logic         byteReady,
    output logic         frameDone,
    output logic         frameError,
    output logic         busy,
    output logic [7:0]   overrunCount
);

    state_t       r_state;
    logic [255:0] r_frame;
    logic [4:0]   r_idx;
    logic         r_nd_q;
    logic         r_armed;

    logic         w_edge;
    logic         w_csum_clr;
    logic         w_csum_add;
    logic [7:0]   w_sum;
    logic [7:0]   w_cur_byte;
    logic [7:0]   w_len;
    logic [7:0]   w_last_idx;
    logic         w_reject;

    // r_armed stays low after reset until newData is seen low, so a level
    // already high when reset releases is never mistaken for a new frame.
    assign w_edge     = newData && !r_nd_q && r_armed;
    assign w_csum_clr = (r_state == ST_IDLE) && w_edge;
    assign w_csum_add = (r_state == ST_CHECK);
    assign w_cur_byte = frame_byte(r_frame, r_idx);
    assign w_len      = r_frame[15:8];
    assign w_last_idx = w_len + 8'd1;
    assign w_reject   = (r_frame[7:0] != SYNC_BYTE) || (w_len > 8'(MAX_LEN))
                        || (w_sum != r_frame[255:248]);
    assign busy       = (r_state != ST_IDLE);

    comms_rx_csum u_csum (
        .clk   (clk),
        .rst   (rst),
        .clear (w_csum_clr),
        .add   (w_csum_add),
        .data  (w_cur_byte),
        .sum   (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_frame      <= '0;
            r_idx        <= 5'd0;
            r_nd_q       <= 1'b0;
            r_armed      <= 1'b0;
            byteOut      <= 8'd0;
            byteValid    <= 1'b0;
            frameDone    <= 1'b0;
            frameError   <= 1'b0;
            overrunCount <= 8'd0;
        end else begin
            r_nd_q     <= newData;
            frameDone  <= 1'b0;
            frameError <= 1'b0;
            if (!newData) begin
                r_armed <= 1'b1;
            end
            // Includes the cycle in which the FSM is about to return to IDLE.
            if (w_edge && (r_state != ST_IDLE) && (overrunCount != 8'hFF)) begin
                overrunCount <= overrunCount + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_frame <= receiveBuffer;
                        r_idx   <= 5'd0;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd30) begin
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (w_reject) begin
                        frameError <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else if (w_len == 8'd0) begin
                        frameDone <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_idx     <= 5'd2;
                        byteOut   <= r_frame[23:16];
                        byteValid <= 1'b1;
                        r_state   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (byteReady) begin
                        if ({3'b000, r_idx} == w_last_idx) begin
                            byteValid <= 1'b0;
                            frameDone <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            byteOut <= frame_byte(r_frame, r_idx + 5'd1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_unpacker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rx_frame_unpacker: directed self-checking bench                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_rx_frame_unpacker;

    logic         clk = 1'b0;
    logic         rst;
    logic         newData;
    logic [255:0] receiveBuffer;
    logic [7:0]   byteOut;
    logic         byteValid;
    logic         byteReady;
    logic         frameDone;
    logic         frameError;
    logic         busy;
    logic [7:0]   overrunCount;

    int total = 0;
    int bad   = 0;

    rx_frame_unpacker #(.SYNC_BYTE(8'hA5), .MAX_LEN(29)) dut (
        .clk           (clk),
        .rst           (rst),
        .newData       (newData),
        .receiveBuffer (receiveBuffer),
        .byteOut       (byteOut),
        .byteValid     (byteValid),
        .byteReady     (byteReady),
        .frameDone     (frameDone),
        .frameError    (frameError),
        .busy          (busy),
        .overrunCount  (overrunCount)
    );

    always #5 clk = ~clk;

    // Frame: sync, length, payload p0..p4 at bytes 2..6, filler at byte 30, checksum + delta.
    function automatic logic [255:0] mk_frame(input logic [7:0] sync, input logic [7:0] len,
                                              input logic [7:0] p0, input logic [7:0] p1,
                                              input logic [7:0] p2, input logic [7:0] p3,
                                              input logic [7:0] p4, input logic [7:0] filler,
                                              input logic [7:0] delta);
        logic [255:0] f;
        logic [7:0]   s;
        f = '0;
        f[7:0]     = sync;
        f[15:8]    = len;
        f[23:16]   = p0;
        f[31:24]   = p1;
        f[39:32]   = p2;
        f[47:40]   = p3;
        f[55:48]   = p4;
        f[247:240] = filler;
        s = 8'd0;
        for (int k = 0; k < 31; k++) s = s + f[k*8 +: 8];
        f[255:248] = s + delta;
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; newData = 1'b0; byteReady = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; newData = 1'b0; byteReady = 1'b0; receiveBuffer = '0;
        tick; tick;
        total++; if (byteOut !== 8'h00) begin bad++; $display("FAIL reset byteOut got=%h exp=00", byteOut); end
        total++; if (byteValid !== 1'b0) begin bad++; $display("FAIL reset byteValid got=%b exp=0", byteValid); end
        total++; if (frameDone !== 1'b0) begin bad++; $display("FAIL reset frameDone got=%b exp=0", frameDone); end
        total++; if (frameError !== 1'b0) begin bad++; $display("FAIL reset frameError got=%b exp=0", frameError); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
        total++; if (overrunCount !== 8'h00) begin bad++; $display("FAIL reset overrunCount got=%h exp=00", overrunCount); end
        rst = 1'b0; byteReady = 1'b1;
        tick;
    endtask

    task automatic test_valid_frame;
        logic       exp_v, exp_d;
        logic [7:0] exp_b;
        receiveBuffer = mk_frame(8'hA5, 8'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h77, 8'h00);
        byteReady = 1'b1; newData = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (n == 1) newData = 1'b0;
            exp_v = (n >= 33 && n <= 35);
            exp_d = (n == 36);
            exp_b = 8'(8'h11 * (n - 32));
            total++;
            if (byteValid !== exp_v) begin bad++; $display("FAIL valid byteValid cyc=%0d got=%b exp=%b", n, byteValid, exp_v); end
            if (exp_v) begin
                total++;
                if (byteOut !== exp_b) begin bad++; $display("FAIL valid byteOut cyc=%0d got=%h exp=%h", n, byteOut, exp_b); end
            end
            total++;
            if (frameDone !== exp_d) begin bad++; $display("FAIL valid frameDone cyc=%0d got=%b exp=%b", n, frameDone, exp_d); end
            total++;
            if (frameError !== 1'b0) begin bad++; $display("FAIL valid frameError cyc=%0d got=%b exp=0", n, frameError); end
            if (n == 1 || n == 36) begin
                total++;
                if (busy !== (n == 1)) begin bad++; $display("FAIL valid busy cyc=%0d got=%b exp=%b", n, busy, (n == 1)); end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] got[$];
        logic       acc;
        logic [7:0] accb;
        int         done_tick;
        int         done_cnt;
        done_tick = -1; done_cnt = 0;
        receiveBuffer = mk_frame(8'hA5, 8'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
        byteReady = 1'b1; newData = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            acc  = byteValid && byteReady;
            accb = byteOut;
            tick;
            if (n == 1) newData = 1'b0;
            if (acc) got.push_back(accb);
            if (frameDone) begin done_cnt++; done_tick = n; end
            if (n >= 34 && n <= 38) begin
                total++;
                if (!(byteValid === 1'b1 && byteOut === 8'h22)) begin
                    bad++; $display("FAIL bp hold cyc=%0d got=%b/%h exp=1/22", n, byteValid, byteOut);
                end
            end
            byteReady = !(n >= 34 && n <= 37);
        end
        total++; if (got.size() != 3) begin bad++; $display("FAIL bp count got=%0d exp=3", got.size()); end
        if (got.size() == 3) begin
            total++;
            if (got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
                bad++; $display("FAIL bp bytes got=%h %h %h exp=11 22 33", got[0], got[1], got[2]);
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL bp done_cnt got=%0d exp=1", done_cnt); end
        total++; if (done_tick != 40) begin bad++; $display("FAIL bp done_tick got=%0d exp=40", done_tick); end
    endtask

    task automatic test_errors;
        logic [255:0] frames [3];
        int err_cnt, err_tick, v_seen, d_seen;
        frames[0] = mk_frame(8'h5A, 8'd3,  8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
        frames[1] = mk_frame(8'hA5, 8'd30, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
        frames[2] = mk_frame(8'hA5, 8'd3,  8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h01);
        for (int i = 0; i < 3; i++) begin
            err_cnt = 0; err_tick = -1; v_seen = 0; d_seen = 0;
            receiveBuffer = frames[i];
            byteReady = 1'b1; newData = 1'b1;
            for (int n = 1; n <= 40; n++) begin
                tick;
                if (n == 1) newData = 1'b0;
                if (frameError) begin err_cnt++; err_tick = n; end
                if (byteValid) v_seen++;
                if (frameDone) d_seen++;
            end
            total++; if (err_cnt != 1) begin bad++; $display("FAIL err%0d count got=%0d exp=1", i, err_cnt); end
            total++; if (err_tick != 33) begin bad++; $display("FAIL err%0d tick got=%0d exp=33", i, err_tick); end
            total++; if (v_seen != 0) begin bad++; $display("FAIL err%0d byteValid cycles got=%0d exp=0", i, v_seen); end
            total++; if (d_seen != 0) begin bad++; $display("FAIL err%0d frameDone cycles got=%0d exp=0", i, d_seen); end
        end
    endtask

    task automatic test_zero_len;
        int done_tick, done_cnt, v_seen, e_seen;
        done_tick = -1; done_cnt = 0; v_seen = 0; e_seen = 0;
        receiveBuffer = mk_frame(8'hA5, 8'd0, 8'hDE, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        byteReady = 1'b1; newData = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (n == 1) newData = 1'b0;
            if (frameDone) begin done_cnt++; done_tick = n; end
            if (byteValid) v_seen++;
            if (frameError) e_seen++;
        end
        total++; if (done_tick != 33) begin bad++; $display("FAIL zero done_tick got=%0d exp=33", done_tick); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zero done_cnt got=%0d exp=1", done_cnt); end
        total++; if (v_seen != 0) begin bad++; $display("FAIL zero byteValid cycles got=%0d exp=0", v_seen); end
        total++; if (e_seen != 0) begin bad++; $display("FAIL zero frameError cycles got=%0d exp=0", e_seen); end
    endtask

    task automatic test_overrun;
        logic [7:0] got[$];
        logic       acc;
        logic [7:0] accb;
        int         done_cnt, e_seen;
        done_cnt = 0; e_seen = 0;
        do_reset;
        receiveBuffer = mk_frame(8'hA5, 8'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
        byteReady = 1'b0; newData = 1'b1;
        for (int n = 1; n <= 33; n++) begin
            tick;
            if (n == 1) newData = 1'b0;
        end
        total++; if (byteValid !== 1'b1 || byteOut !== 8'h11) begin bad++; $display("FAIL ovr first got=%b/%h exp=1/11", byteValid, byteOut); end
        for (int e = 1; e <= 300; e++) begin
            receiveBuffer = '1;
            newData = 1'b1; tick;
            newData = 1'b0; tick;
            if (frameError) e_seen++;
            if (e == 10) begin
                total++; if (overrunCount !== 8'd10) begin bad++; $display("FAIL ovr count10 got=%0d exp=10", overrunCount); end
            end
        end
        total++; if (overrunCount !== 8'd255) begin bad++; $display("FAIL ovr saturate got=%0d exp=255", overrunCount); end
        total++; if (byteValid !== 1'b1 || byteOut !== 8'h11) begin bad++; $display("FAIL ovr hold got=%b/%h exp=1/11", byteValid, byteOut); end
        byteReady = 1'b1;
        for (int n = 0; n < 8; n++) begin
            acc = byteValid && byteReady; accb = byteOut;
            tick;
            if (acc) got.push_back(accb);
            if (frameDone) done_cnt++;
            if (frameError) e_seen++;
        end
        total++; if (got.size() != 3) begin bad++; $display("FAIL ovr count got=%0d exp=3", got.size()); end
        if (got.size() == 3) begin
            total++;
            if (got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
                bad++; $display("FAIL ovr bytes got=%h %h %h exp=11 22 33", got[0], got[1], got[2]);
            end
        end
        total++; if (done_cnt != 1 || e_seen != 0) begin bad++; $display("FAIL ovr pulses got=done%0d/err%0d exp=1/0", done_cnt, e_seen); end
    endtask

    task automatic test_reset_mid_stream;
        logic [7:0] got[$];
        logic       acc;
        logic [7:0] accb;
        int         pulses, done_cnt;
        pulses = 0; done_cnt = 0;
        receiveBuffer = mk_frame(8'hA5, 8'd5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00);
        byteReady = 1'b1; newData = 1'b1;
        for (int n = 1; n <= 35; n++) begin
            tick;
            if (n == 1) newData = 1'b0;
        end
        total++; if (byteValid !== 1'b1 || byteOut !== 8'h03) begin bad++; $display("FAIL rms pre got=%b/%h exp=1/03", byteValid, byteOut); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++; if (byteOut !== 8'h00) begin bad++; $display("FAIL rms byteOut got=%h exp=00", byteOut); end
        total++; if (byteValid !== 1'b0) begin bad++; $display("FAIL rms byteValid got=%b exp=0", byteValid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rms busy got=%b exp=0", busy); end
        total++; if (frameDone !== 1'b0 || frameError !== 1'b0) begin bad++; $display("FAIL rms pulses got=%b%b exp=00", frameDone, frameError); end
        total++; if (overrunCount !== 8'h00) begin bad++; $display("FAIL rms overrunCount got=%h exp=00", overrunCount); end
        for (int n = 0; n < 5; n++) begin
            tick;
            if (frameDone || frameError || byteValid) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL rms after got=%0d exp=0", pulses); end
        receiveBuffer = mk_frame(8'hA5, 8'd3, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00);
        newData = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            acc = byteValid && byteReady; accb = byteOut;
            tick;
            if (n == 1) newData = 1'b0;
            if (acc) got.push_back(accb);
            if (frameDone) done_cnt++;
        end
        total++; if (got.size() != 3) begin bad++; $display("FAIL rms next count got=%0d exp=3", got.size()); end
        if (got.size() == 3) begin
            total++;
            if (got[0] !== 8'hAA || got[1] !== 8'hBB || got[2] !== 8'hCC) begin
                bad++; $display("FAIL rms next bytes got=%h %h %h exp=AA BB CC", got[0], got[1], got[2]);
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL rms next done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_newdata_high;
        int busy_seen, done_tick;
        busy_seen = 0; done_tick = -1;
        receiveBuffer = mk_frame(8'hA5, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b1; newData = 1'b1;
        tick;
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick;
            if (busy || frameDone) busy_seen++;
        end
        total++; if (busy_seen != 0) begin bad++; $display("FAIL rnh stale edge got=%0d exp=0", busy_seen); end
        newData = 1'b0;
        tick;
        newData = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (n == 1) newData = 1'b0;
            if (frameDone) done_tick = n;
        end
        total++; if (done_tick != 33) begin bad++; $display("FAIL rnh done_tick got=%0d exp=33", done_tick); end
    endtask

    initial begin
        rst = 1'b1; newData = 1'b0; byteReady = 1'b0; receiveBuffer = '0;
        test_reset;
        test_valid_frame;
        test_backpressure;
        test_errors;
        test_zero_len;
        test_overrun;
        test_reset_mid_stream;
        test_reset_newdata_high;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
